// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types for jump-target formation.
package mips_pkg;

  localparam int unsigned PC_HI_W = 4;
  localparam int unsigned IDX_W   = 26;
  localparam int unsigned ALIGN_W = 2;
  localparam int unsigned ADDR_W  = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [IDX_W-1:0]  jidx_t;

endpackage

// File: rtl/jaddr_concat.sv
// Combinational J-type target: {pc_hi, index, word-alignment zeros}.
module jaddr_concat
  import mips_pkg::*;
#(
  parameter int unsigned PcHiW  = mips_pkg::PC_HI_W,
  parameter int unsigned IdxW   = mips_pkg::IDX_W,
  parameter int unsigned AlignW = mips_pkg::ALIGN_W,
  parameter int unsigned AddrW  = mips_pkg::ADDR_W
) (
  input  logic [PcHiW-1:0] pc,
  input  logic [IdxW-1:0]  a,
  output logic [AddrW-1:0] y
);

  assign y = {pc, a, {AlignW{1'b0}}};

endmodule

// File: rtl/shift_pc.sv
// MIPS jump-target former with a combinational output and a one-entry
// valid/ready registered copy for pipelined next-PC logic.
module shift_pc
  import mips_pkg::*;
#(
  parameter int unsigned PcHiW  = mips_pkg::PC_HI_W,
  parameter int unsigned IdxW   = mips_pkg::IDX_W,
  parameter int unsigned AlignW = mips_pkg::ALIGN_W,
  parameter int unsigned AddrW  = mips_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PcHiW-1:0] pc,
  input  logic [IdxW-1:0]  a,
  output logic [AddrW-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AddrW-1:0] y_q
);

  if (AddrW != PcHiW + IdxW + AlignW) begin : gen_width_check
    $error("shift_pc: AddrW must equal PcHiW + IdxW + AlignW");
  end

  logic [AddrW-1:0] addr_q;
  logic             valid_q;

  jaddr_concat #(
    .PcHiW  (PcHiW),
    .IdxW   (IdxW),
    .AlignW (AlignW),
    .AddrW  (AddrW)
  ) u_concat (
    .pc (pc),
    .a  (a),
    .y  (y)
  );

  // Accept whenever the slot is empty or is being drained this cycle.
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign y_q       = addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      addr_q  <= y;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_pc.sv
// Directed bench for shift_pc: combinational target and registered handshake.
module tb_shift_pc;

  logic        clk;
  logic        rst;
  logic [3:0]  pc;
  logic [25:0] a;
  logic [31:0] y;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_q;

  int total = 0;
  int bad   = 0;

  shift_pc dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .a         (a),
    .y         (y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_q       (y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    pc        = 4'h0;
    a         = 26'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    // Reset state and all-zero target
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_y_q", y_q, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("y_zero", y, 32'h00000000);

    step();
    pc = 4'hF; a = 26'h3FFFFFF;
    @(negedge clk);
    check("y_ones", y, 32'hFFFFFFFC);
    check("y_ones_low", {30'b0, y[1:0]}, 32'h0);

    step();
    pc = 4'h4; a = 26'h0000001;
    @(negedge clk);
    check("y_one", y, 32'h40000004);

    step();
    pc = 4'h5; a = 26'h2AAAAAA;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("y_alt", y, 32'h5AAAAAA8);
    check("pre_cap_in_ready", {31'b0, in_ready}, 32'h1);

    // Capture, then stall with new inputs presented
    step();
    out_ready = 1'b0;
    pc = 4'h9; a = 26'h1234567;
    @(negedge clk);
    check("cap_y_q", y_q, 32'h5AAAAAA8);
    check("cap_out_valid", {31'b0, out_valid}, 32'h1);
    check("stall_in_ready", {31'b0, in_ready}, 32'h0);

    step();
    @(negedge clk);
    check("stall_y_q", y_q, 32'h5AAAAAA8);
    check("stall_out_valid", {31'b0, out_valid}, 32'h1);
    check("stall_y_comb", y, 32'h948D159C);

    // Back-to-back stream with consumer ready
    step();
    out_ready = 1'b1;
    pc = 4'h1; a = 26'h1;
    step();
    pc = 4'h2; a = 26'h2;
    @(negedge clk);
    check("stream1_y_q", y_q, 32'h10000004);
    check("stream1_valid", {31'b0, out_valid}, 32'h1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("stream2_y_q", y_q, 32'h20000008);
    check("stream2_valid", {31'b0, out_valid}, 32'h1);

    // Reset while holding a valid target; y keeps tracking inputs
    step();
    rst = 1'b0;
    pc = 4'h3; a = 26'h3;
    @(negedge clk);
    check("in_rst_y", y, 32'h3000000C);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'b0, out_valid}, 32'h0);
    check("post_rst_y_q", y_q, 32'h0);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Capture all-ones, then consume without new input: y_q holds
    step();
    pc = 4'hF; a = 26'h3FFFFFF;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("ones_y_q", y_q, 32'hFFFFFFFC);
    check("ones_valid", {31'b0, out_valid}, 32'h1);
    step();
    @(negedge clk);
    check("drain_valid", {31'b0, out_valid}, 32'h0);
    check("drain_y_q_hold", y_q, 32'hFFFFFFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
